// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned SEG_NIB_W = 4;

  // Common-anode digits are enabled by driving the anode low.
  localparam logic AN_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot counter: counts 0..REFRESH_DIV-1 while run_i is high and clears
// synchronously when it is low. Flags are given for the current and next count.
module seg_slot_timer #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  output logic blank_phase_next_o,
  output logic slot_end_o,
  output logic slot_end_next_o
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign slot_end_o         = (cnt_q == LastCnt);
  assign slot_end_next_o    = (cnt_d == LastCnt);
  assign blank_phase_next_o = (cnt_d < BlankCnt);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display with a
// double-buffered value. Define SEG_SCAN_LZ_BLANK_EN for leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            enable_i,
  input  logic                            load_i,
  input  logic [SEG_NIB_W*NUM_DIGITS-1:0] value_i,
  input  logic                            sign_i,
  output logic [SEG_NIB_W-1:0]            digit_nib_o,
  output logic                            sign_o,
  output logic [NUM_DIGITS-1:0]           an_o,
  output logic                            frame_done_o,
  output logic                            pending_o
);

  localparam int unsigned ValW = SEG_NIB_W * NUM_DIGITS;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  scan_state_t     state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [ValW-1:0] shadow_val_q, shadow_val_d, pend_val_q, pend_val_d;
  logic            shadow_sign_q, shadow_sign_d, pend_sign_q, pend_sign_d;
  logic            pend_flag_q, pend_flag_d;

  logic [SEG_NIB_W-1:0]  digit_nib_q, digit_nib_d;
  logic                  sign_q, sign_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic run, blank_next, slot_end, slot_end_next, boundary, digit_lit;

  assign run = enable_i && (state_q != IDLE);

  seg_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .run_i             (run),
    .blank_phase_next_o(blank_next),
    .slot_end_o        (slot_end),
    .slot_end_next_o   (slot_end_next)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  function automatic logic upper_zero(input logic [ValW-1:0] val, input logic [IdxW-1:0] from);
    logic z;
    z = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= 32'(from)) && (val[SEG_NIB_W*j +: SEG_NIB_W] != '0)) z = 1'b0;
    end
    return z;
  endfunction
`endif

  assign boundary = (state_q == DRIVE) && slot_end && (idx_q == LastIdx);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_val_d  = shadow_val_q;
    shadow_sign_d = shadow_sign_q;
    pend_val_d    = pend_val_q;
    pend_sign_d   = pend_sign_q;
    pend_flag_d   = pend_flag_q;

    if (!enable_i) begin
      state_d = IDLE;
      idx_d   = '0;
      if (pend_flag_q) begin
        shadow_val_d  = pend_val_q;
        shadow_sign_d = pend_sign_q;
      end
      pend_flag_d = 1'b0;
      if (load_i) begin
        shadow_val_d  = value_i;
        shadow_sign_d = sign_i;
      end
    end else if (state_q == IDLE) begin
      state_d = BLANK;
      idx_d   = '0;
      if (load_i) begin
        shadow_val_d  = value_i;
        shadow_sign_d = sign_i;
      end
    end else begin
      state_d = blank_next ? BLANK : DRIVE;
      if ((state_q == DRIVE) && slot_end) begin
        idx_d = boundary ? '0 : idx_q + IdxW'(1);
      end
      // A load landing on the boundary itself bypasses the pending buffer.
      if (boundary) begin
        if (load_i) begin
          shadow_val_d  = value_i;
          shadow_sign_d = sign_i;
        end else if (pend_flag_q) begin
          shadow_val_d  = pend_val_q;
          shadow_sign_d = pend_sign_q;
        end
        pend_flag_d = 1'b0;
      end else if (load_i) begin
        pend_val_d  = value_i;
        pend_sign_d = sign_i;
        pend_flag_d = 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  assign digit_lit = (idx_d == '0) || !upper_zero(shadow_val_d, idx_d);
`else
  assign digit_lit = 1'b1;
`endif

  // Outputs are registered from next-state values so they line up with state.
  always_comb begin
    an_d = {NUM_DIGITS{AN_OFF}};
    if ((state_d == DRIVE) && digit_lit) begin
      an_d[idx_d] = ~AN_OFF;
    end
    digit_nib_d  = shadow_val_d[SEG_NIB_W*idx_d +: SEG_NIB_W];
    sign_d       = shadow_sign_d && (idx_d == LastIdx);
    frame_done_d = (state_d == DRIVE) && (idx_d == LastIdx) && slot_end_next;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_sign_q <= 1'b0;
      pend_val_q    <= '0;
      pend_sign_q   <= 1'b0;
      pend_flag_q   <= 1'b0;
      an_q          <= {NUM_DIGITS{AN_OFF}};
      digit_nib_q   <= '0;
      sign_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_sign_q <= shadow_sign_d;
      pend_val_q    <= pend_val_d;
      pend_sign_q   <= pend_sign_d;
      pend_flag_q   <= pend_flag_d;
      an_q          <= an_d;
      digit_nib_q   <= digit_nib_d;
      sign_q        <= sign_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign an_o         = an_q;
  assign digit_nib_o  = digit_nib_q;
  assign sign_o       = sign_q;
  assign frame_done_o = frame_done_q;
  assign pending_o    = pend_flag_q;

endmodule
